// File: rtl/dcache_uncached_resp.sv
// dcache_uncached_resp
//
// Uncached responder for the single-lane EX1 data-memory request. One
// request is taken at a time in IDLE. The access runs on a simple SRAM-like
// read/write bus, and completion is returned to EX2 as a one-cycle data_ok
// pulse with the raw read word (or the SC result) and the misalignment flag.
//
// Build option:
//   DCACHE_LLBIT_EN  defined   -> LL sets the link bit, SC checks and clears it,
//                                 llbit_clear wipes it.
//                    undefined -> no link bit. LL is a plain read. SC always
//                                 writes and reports success.

module dcache_uncached_resp #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              flush,
  input  logic              llbit_clear,
  // EX1 request
  input  logic              valid_dcache,
  input  logic              op_dcache,
  input  logic [3:0]        write_type_dcache,
  input  logic [ADDR_W-1:0] addr_dcache,
  input  logic [31:0]       w_data_dcache,
  input  logic              is_atom_dcache,
  // EX2 response
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       r_data,
  output logic              ale,
  // bus read channel
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic [31:0]       ret_data,
  // bus write channel
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_wstrb,
  output logic [31:0]       wr_data,
  input  logic              wr_rdy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RREQ,
    S_RWAIT,
    S_RDROP,
    S_WREQ,
    S_RESP
  } state_t;

  state_t            state;

  // Registered request and output-side state.
  logic [ADDR_W-1:0] bus_addr;
  logic              req_atom;
  logic              rd_req_q;
  logic              wr_req_q;
  logic              resp_q;

  // Decode of the incoming request, used only on the accept cycle.
  logic              is_half;
  logic              is_word;
  logic              misaligned;
  logic              sc_fail;
  logic              accept;
  logic [3:0]        lane_strb;
  logic [31:0]       lane_data;

  // Link-bit view seen by the accept logic: the real bit when LL/SC is
  // built in, otherwise permanently "linked" so SC always proceeds.
  logic              llbit_ok;

  assign accept = (state == S_IDLE) & valid_dcache & ~flush;

  // Size decode, alignment check and lane placement of the store data.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned; that is what keeps this from becoming a latch.
  always_comb begin
    is_half    = 1'b0;
    is_word    = 1'b0;
    misaligned = 1'b0;
    sc_fail    = 1'b0;
    lane_strb  = 4'b0000;
    lane_data  = {4{w_data_dcache[7:0]}};

    is_word    = (write_type_dcache == 4'b1111);
    is_half    = (write_type_dcache == 4'b0011);
    misaligned = (is_word & (addr_dcache[1:0] != 2'b00)) |
                 (is_half & addr_dcache[0]);
    sc_fail    = is_atom_dcache & op_dcache & ~llbit_ok;
    lane_strb  = write_type_dcache << addr_dcache[1:0];

    // Replicate the low-aligned store data across the word so that whichever
    // lanes the strobe selects carry the right bytes.
    if (is_word) begin
      lane_data = w_data_dcache;
    end else if (is_half) begin
      lane_data = {2{w_data_dcache[15:0]}};
    end
  end

`ifdef DCACHE_LLBIT_EN
  logic llbit;
  logic ll_set;
  logic sc_done;

  // An LL sets the bit only when its data actually returns to the pipeline.
  assign ll_set  = (state == S_RWAIT) & ret_valid & ~flush & req_atom;
  // A committed SC consumes the link, even when its response is flushed.
  assign sc_done = (state == S_WREQ) & wr_rdy & req_atom;

  assign llbit_ok = llbit;

  // Link bit: an explicit clear wins over a simultaneous LL set.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      llbit <= 1'b0;
    end else if (llbit_clear) begin
      llbit <= 1'b0;
    end else if (ll_set) begin
      llbit <= 1'b1;
    end else if (sc_done) begin
      llbit <= 1'b0;
    end
  end
`else
  // Without LL/SC support the clear input has nothing to act on.
  logic unused_llbit_clear;

  assign unused_llbit_clear = llbit_clear;
  assign llbit_ok           = 1'b1;
`endif

  // Request FSM with registered bus-request and response outputs.
  // NOTE: state is updated only with non-blocking assignments, so every
  // branch below reads the values from before this clock edge.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      bus_addr <= '0;
      req_atom <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      resp_q   <= 1'b0;
      r_data   <= '0;
      ale      <= 1'b0;
      wr_wstrb <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            bus_addr <= {addr_dcache[ADDR_W-1:2], 2'b00};
            req_atom <= is_atom_dcache;
            wr_wstrb <= lane_strb;
            wr_data  <= lane_data;
            ale      <= misaligned;
            r_data   <= '0;
            if (misaligned || sc_fail) begin
              // Answered locally: misaligned access or an SC without a link.
              state  <= S_RESP;
              resp_q <= 1'b1;
            end else if (op_dcache) begin
              state    <= S_WREQ;
              wr_req_q <= 1'b1;
            end else begin
              state    <= S_RREQ;
              rd_req_q <= 1'b1;
            end
          end
        end

        S_RREQ: begin
          if (flush) begin
            // Nothing has reached the bus yet, so the read is simply dropped.
            state    <= S_IDLE;
            rd_req_q <= 1'b0;
          end else if (rd_rdy) begin
            state    <= S_RWAIT;
            rd_req_q <= 1'b0;
          end
        end

        S_RWAIT: begin
          if (ret_valid) begin
            if (flush) begin
              // The return and the flush coincide: the data is consumed
              // and thrown away.
              state <= S_IDLE;
            end else begin
              r_data <= ret_data;
              state  <= S_RESP;
              resp_q <= 1'b1;
            end
          end else if (flush) begin
            // The bus still owes us a return; wait for it and discard it.
            state <= S_RDROP;
          end
        end

        S_RDROP: begin
          if (ret_valid) begin
            state <= S_IDLE;
          end
        end

        S_WREQ: begin
          if (wr_rdy) begin
            // The write is committed on the bus even when a flush arrives
            // in the same cycle; only the response is then withheld.
            wr_req_q <= 1'b0;
            r_data   <= {31'd0, req_atom};
            if (flush) begin
              state <= S_IDLE;
            end else begin
              state  <= S_RESP;
              resp_q <= 1'b1;
            end
          end else if (flush) begin
            state    <= S_IDLE;
            wr_req_q <= 1'b0;
          end
        end

        S_RESP: begin
          state  <= S_IDLE;
          resp_q <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          rd_req_q <= 1'b0;
          wr_req_q <= 1'b0;
          resp_q   <= 1'b0;
        end
      endcase
    end
  end

  assign addr_ok = accept;
  // A flush in RESP withholds the completion pulse.
  assign data_ok = resp_q & ~flush;
  // A flush in RREQ pulls the read request off the bus in the same cycle.
  assign rd_req  = rd_req_q & ~flush;
  assign wr_req  = wr_req_q;
  assign rd_addr = bus_addr;
  assign wr_addr = bus_addr;

endmodule

// File: tb/tb_dcache_uncached_resp.sv
// Self-checking bench for dcache_uncached_resp.
// Directed scenarios followed by randomized transactions. Expected values
// come from a lane-level reference model of the access rules.

module tb_dcache_uncached_resp;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic              flush = 1'b0;
  logic              llbit_clear = 1'b0;
  logic              valid_dcache = 1'b0;
  logic              op_dcache = 1'b0;
  logic [3:0]        write_type_dcache = 4'b0001;
  logic [ADDR_W-1:0] addr_dcache = '0;
  logic [31:0]       w_data_dcache = '0;
  logic              is_atom_dcache = 1'b0;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       r_data;
  logic              ale;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rdy = 1'b0;
  logic              ret_valid = 1'b0;
  logic [31:0]       ret_data = '0;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_wstrb;
  logic [31:0]       wr_data;
  logic              wr_rdy = 1'b0;

  int checks = 0;
  int errors = 0;
  bit m_llbit = 1'b0;

  dcache_uncached_resp #(.ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .flush             (flush),
    .llbit_clear       (llbit_clear),
    .valid_dcache      (valid_dcache),
    .op_dcache         (op_dcache),
    .write_type_dcache (write_type_dcache),
    .addr_dcache       (addr_dcache),
    .w_data_dcache     (w_data_dcache),
    .is_atom_dcache    (is_atom_dcache),
    .addr_ok           (addr_ok),
    .data_ok           (data_ok),
    .r_data            (r_data),
    .ale               (ale),
    .rd_req            (rd_req),
    .rd_addr           (rd_addr),
    .rd_rdy            (rd_rdy),
    .ret_valid         (ret_valid),
    .ret_data          (ret_data),
    .wr_req            (wr_req),
    .wr_addr           (wr_addr),
    .wr_wstrb          (wr_wstrb),
    .wr_data           (wr_data),
    .wr_rdy            (wr_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive point is just after the rising edge; sampling is on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [3:0] wt);
    if (wt == 4'b1111) return 4;
    if (wt == 4'b0011) return 2;
    return 1;
  endfunction

  function automatic bit is_mis(input logic [3:0] wt, input logic [31:0] a);
    return (int'(a[1:0]) % size_of(wt)) != 0;
  endfunction

  // Lanes covered by the access: bytes off .. off+size-1 of the word.
  function automatic logic [3:0] exp_strb(input logic [3:0] wt, input logic [31:0] a);
    logic [3:0] s;
    int off;
    s   = 4'b0000;
    off = int'(a[1:0]);
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + size_of(wt));
    return s;
  endfunction

  // Lane i carries byte (i mod size) of the low-aligned store data.
  function automatic logic [31:0] exp_wdata(input logic [3:0] wt, input logic [31:0] wd);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % size_of(wt)) +: 8];
    return d;
  endfunction

  // ---------------- transaction tasks ----------------
  task automatic issue(input bit op, input logic [3:0] wt, input logic [31:0] a,
                       input logic [31:0] wd, input bit atom, input string tag);
    valid_dcache      = 1'b1;
    op_dcache         = op;
    write_type_dcache = wt;
    addr_dcache       = a;
    w_data_dcache     = wd;
    is_atom_dcache    = atom;
    sample();
    check({tag, ".addr_ok"}, addr_ok, 1);
    check({tag, ".idle_data_ok"}, data_ok, 0);
    step();
    valid_dcache = 1'b0;
  endtask

  task automatic short_resp(input bit mis, input string tag);
    sample();
    check({tag, ".data_ok"}, data_ok, 1);
    check({tag, ".ale"}, ale, mis);
    if (!mis) check({tag, ".sc_fail_rdata"}, r_data, 0);
    check({tag, ".no_rd_req"}, rd_req, 0);
    check({tag, ".no_wr_req"}, wr_req, 0);
    step();
    sample();
    check({tag, ".pulse_end"}, data_ok, 0);
    check({tag, ".no_rd_req2"}, rd_req, 0);
    check({tag, ".no_wr_req2"}, wr_req, 0);
    step();
  endtask

  task automatic read_txn(input logic [3:0] wt, input logic [31:0] a, input bit atom,
                          input int rdy_d, input int ret_d, input logic [31:0] rd,
                          input string tag);
    bit mis;
    mis = is_mis(wt, a);
    issue(1'b0, wt, a, 32'h0, atom, tag);
    if (mis) begin
      short_resp(1'b1, tag);
      return;
    end
    for (int c = 0; c <= rdy_d; c++) begin
      rd_rdy = (c == rdy_d);
      sample();
      check({tag, ".rd_req"}, rd_req, 1);
      check({tag, ".rd_addr"}, rd_addr, {a[31:2], 2'b00});
      check({tag, ".early_data_ok"}, data_ok, 0);
      check({tag, ".rd_no_wr_req"}, wr_req, 0);
      step();
    end
    rd_rdy       = 1'b0;
    valid_dcache = 1'b1;
    for (int c = 0; c <= ret_d; c++) begin
      ret_valid = (c == ret_d);
      ret_data  = ret_valid ? rd : $urandom;
      if (ret_valid) valid_dcache = 1'b0;
      sample();
      check({tag, ".wait_data_ok"}, data_ok, 0);
      check({tag, ".wait_rd_req"}, rd_req, 0);
      if (valid_dcache) check({tag, ".busy_addr_ok"}, addr_ok, 0);
      step();
    end
    ret_valid = 1'b0;
`ifdef DCACHE_LLBIT_EN
    if (atom) m_llbit = 1'b1;
`endif
    sample();
    check({tag, ".data_ok"}, data_ok, 1);
    check({tag, ".r_data"}, r_data, rd);
    check({tag, ".ale"}, ale, 0);
    step();
    sample();
    check({tag, ".pulse_end"}, data_ok, 0);
    step();
  endtask

  task automatic write_txn(input logic [3:0] wt, input logic [31:0] a, input logic [31:0] wd,
                           input bit atom, input int rdy_d, input string tag);
    bit mis;
    bit sc_fail;
    mis     = is_mis(wt, a);
    sc_fail = 1'b0;
`ifdef DCACHE_LLBIT_EN
    sc_fail = atom && !m_llbit;
`endif
    issue(1'b1, wt, a, wd, atom, tag);
    if (mis || sc_fail) begin
      short_resp(mis, tag);
      return;
    end
    for (int c = 0; c <= rdy_d; c++) begin
      wr_rdy = (c == rdy_d);
      sample();
      check({tag, ".wr_req"}, wr_req, 1);
      check({tag, ".wr_addr"}, wr_addr, {a[31:2], 2'b00});
      check({tag, ".wr_wstrb"}, wr_wstrb, exp_strb(wt, a));
      check({tag, ".wr_data"}, wr_data, exp_wdata(wt, wd));
      check({tag, ".early_data_ok"}, data_ok, 0);
      check({tag, ".wr_no_rd_req"}, rd_req, 0);
      step();
    end
    wr_rdy = 1'b0;
`ifdef DCACHE_LLBIT_EN
    if (atom) m_llbit = 1'b0;
`endif
    sample();
    check({tag, ".data_ok"}, data_ok, 1);
    check({tag, ".ale"}, ale, 0);
    if (atom) check({tag, ".sc_rdata"}, r_data, 1);
    step();
    sample();
    check({tag, ".pulse_end"}, data_ok, 0);
    check({tag, ".wr_req_end"}, wr_req, 0);
    step();
  endtask

  task automatic pulse_llbit_clear();
    llbit_clear = 1'b1;
    step();
    llbit_clear = 1'b0;
    m_llbit     = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".addr_ok"}, addr_ok, 0);
    check({tag, ".data_ok"}, data_ok, 0);
    check({tag, ".r_data"}, r_data, 0);
    check({tag, ".ale"}, ale, 0);
    check({tag, ".rd_req"}, rd_req, 0);
    check({tag, ".rd_addr"}, rd_addr, 0);
    check({tag, ".wr_req"}, wr_req, 0);
    check({tag, ".wr_addr"}, wr_addr, 0);
    check({tag, ".wr_wstrb"}, wr_wstrb, 0);
    check({tag, ".wr_data"}, wr_data, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rd;
    logic [3:0]  wt;
    bit          op;
    bit          atom;

    // Reset state.
    step();
    step();
    sample();
    check_reset_outputs("reset");
    step();
    aresetn = 1'b1;
    step();
    sample();
    check_reset_outputs("post_reset");
    step();

    // Word read: rd_rdy at cycle 1, return at cycle 3, data_ok at cycle 4.
    read_txn(4'b1111, 32'h0000_1000, 1'b0, 0, 1, 32'hDEAD_BEEF, "word_read");

    // Byte store 0xAB at 0x2003: strobe 1000, data in the top lane.
    write_txn(4'b0001, 32'h0000_2003, 32'h0000_00AB, 1'b0, 0, "byte_store");

    // Misaligned word read: completes at cycle 1 with ale, no bus traffic.
    read_txn(4'b1111, 32'h0000_3002, 1'b0, 0, 0, 32'h0, "mis_word");
    write_txn(4'b0011, 32'h0000_3001, 32'h0000_5A5A, 1'b0, 0, "mis_half_st");

    // LL/SC sequence; outcomes depend on whether the link bit is built in.
    read_txn(4'b1111, 32'h0000_4000, 1'b1, 0, 0, 32'h0BAD_F00D, "ll1");
    write_txn(4'b1111, 32'h0000_4000, 32'h1111_2222, 1'b1, 1, "sc1");
    write_txn(4'b1111, 32'h0000_4000, 32'h3333_4444, 1'b1, 0, "sc2");
    read_txn(4'b1111, 32'h0000_4000, 1'b1, 1, 0, 32'h5555_6666, "ll2");
    pulse_llbit_clear();
    write_txn(4'b1111, 32'h0000_4000, 32'h7777_8888, 1'b1, 0, "sc3");

    // Flush in RWAIT, return two cycles later, next request right after it.
    issue(1'b0, 4'b1111, 32'h0000_5004, 32'h0, 1'b0, "frw");
    rd_rdy = 1'b1;
    sample();
    check("frw.rd_req", rd_req, 1);
    step();
    rd_rdy = 1'b0;
    flush  = 1'b1;
    sample();
    check("frw.flush_data_ok", data_ok, 0);
    step();
    flush = 1'b0;
    sample();
    check("frw.drop_data_ok", data_ok, 0);
    check("frw.drop_rd_req", rd_req, 0);
    step();
    ret_valid         = 1'b1;
    ret_data          = 32'h1234_5678;
    valid_dcache      = 1'b1;
    op_dcache         = 1'b1;
    write_type_dcache = 4'b1111;
    addr_dcache       = 32'h0000_5008;
    sample();
    check("frw.ret_addr_ok", addr_ok, 0);
    check("frw.ret_data_ok", data_ok, 0);
    step();
    ret_valid = 1'b0;
    write_txn(4'b1111, 32'h0000_5008, 32'hCAFE_0001, 1'b0, 0, "frw.next");

    // Flush in RREQ: the read is abandoned.
    issue(1'b0, 4'b1111, 32'h0000_6000, 32'h0, 1'b0, "frq");
    flush = 1'b1;
    step();
    flush = 1'b0;
    sample();
    check("frq.rd_req", rd_req, 0);
    check("frq.data_ok", data_ok, 0);
    step();

    // Flush in WREQ without wr_rdy: the write is dropped.
    issue(1'b1, 4'b0011, 32'h0000_6002, 32'h1234_BEEF, 1'b0, "fwq");
    flush = 1'b1;
    sample();
    check("fwq.wr_req", wr_req, 1);
    check("fwq.wr_wstrb", wr_wstrb, 4'b1100);
    check("fwq.wr_data", wr_data, 32'hBEEF_BEEF);
    step();
    flush = 1'b0;
    sample();
    check("fwq.wr_req_end", wr_req, 0);
    check("fwq.data_ok", data_ok, 0);
    step();

    // Flush together with wr_rdy: committed, but no data_ok.
    issue(1'b1, 4'b1111, 32'h0000_6010, 32'hA5A5_0F0F, 1'b0, "fwr");
    flush  = 1'b1;
    wr_rdy = 1'b1;
    sample();
    check("fwr.wr_req", wr_req, 1);
    check("fwr.wr_data", wr_data, 32'hA5A5_0F0F);
    step();
    flush  = 1'b0;
    wr_rdy = 1'b0;
    sample();
    check("fwr.data_ok", data_ok, 0);
    check("fwr.wr_req_end", wr_req, 0);
    step();

    // Flush in RESP suppresses the pulse.
    issue(1'b0, 4'b0011, 32'h0000_6001, 32'h0, 1'b0, "frs");
    flush = 1'b1;
    sample();
    check("frs.data_ok", data_ok, 0);
    step();
    flush = 1'b0;
    sample();
    check("frs.data_ok_after", data_ok, 0);
    check("frs.rd_req", rd_req, 0);
    step();

    // Flush in IDLE rejects the request.
    valid_dcache      = 1'b1;
    op_dcache         = 1'b0;
    write_type_dcache = 4'b1111;
    addr_dcache       = 32'h0000_7000;
    flush             = 1'b1;
    sample();
    check("fidle.addr_ok", addr_ok, 0);
    step();
    valid_dcache = 1'b0;
    flush        = 1'b0;
    sample();
    check("fidle.rd_req", rd_req, 0);
    check("fidle.data_ok", data_ok, 0);
    step();

    // Reset in the middle of a read returns to IDLE at once.
    issue(1'b0, 4'b1111, 32'h0000_7100, 32'h0, 1'b0, "mreset");
    rd_rdy = 1'b1;
    step();
    rd_rdy  = 1'b0;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("mreset");
    step();
    aresetn = 1'b1;
    m_llbit = 1'b0;
    step();
    read_txn(4'b0001, 32'h0000_7105, 1'b0, 0, 0, 32'h89AB_CDEF, "after_reset");

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rd = $urandom;
      op = 1'($urandom_range(0, 1));
      atom = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       wt = 4'b0001;
        1:       wt = 4'b0011;
        default: wt = 4'b1111;
      endcase
      if ($urandom_range(0, 7) == 0) pulse_llbit_clear();
      if (op) write_txn(wt, ra, rd, atom, int'($urandom_range(0, 2)), "rnd_wr");
      else    read_txn(wt, ra, atom, int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 2)), rd, "rnd_rd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
